// File: rtl/bp_nonsynth_commit_packer.sv
// In-order commit record packer: pairs each committing instruction with its (possibly late)
// int/fp writeback data and emits fully-resolved records over a valid/yumi handshake.
module bp_nonsynth_commit_packer
  #(parameter int unsigned vaddr_width_p = 39
    , parameter int unsigned dword_width_p = 64
    , parameter int unsigned commit_els_p  = 16
    , parameter int unsigned wb_els_p      = 2
    )
  (input  logic                     clk_i
   , input  logic                     reset_i

   , input  logic                     commit_v_i
   , input  logic                     commit_trap_i
   , input  logic [vaddr_width_p-1:0] commit_pc_i
   , input  logic [31:0]              commit_instr_i
   , input  logic                     commit_ird_w_v_i
   , input  logic                     commit_frd_w_v_i
   , input  logic [dword_width_p-1:0] commit_cause_i

   , input  logic                     iwb_v_i
   , input  logic [4:0]               iwb_addr_i
   , input  logic [dword_width_p-1:0] iwb_data_i
   , input  logic                     fwb_v_i
   , input  logic [4:0]               fwb_addr_i
   , input  logic [dword_width_p-1:0] fwb_data_i

   , output logic                     rec_v_o
   , input  logic                     rec_yumi_i
   , output logic                     rec_trap_o
   , output logic [vaddr_width_p-1:0] rec_pc_o
   , output logic [31:0]              rec_instr_o
   , output logic                     rec_rd_w_v_o
   , output logic                     rec_rd_fp_o
   , output logic [4:0]               rec_rd_addr_o
   , output logic [dword_width_p-1:0] rec_rd_data_o
   , output logic                     overflow_o
   );

  localparam int unsigned cq_ptr_w_lp  = $clog2(commit_els_p);
  localparam int unsigned cq_cnt_w_lp  = cq_ptr_w_lp + 1;
  localparam int unsigned wb_cnt_w_lp  = $clog2(wb_els_p + 1);
  localparam int unsigned wb_regs_lp   = 64;

  typedef struct packed {
    logic                     trap;
    logic [vaddr_width_p-1:0] pc;
    logic [31:0]              instr;
    logic                     ird;
    logic                     frd;
    logic [dword_width_p-1:0] cause;
  } commit_s;

  commit_s                  cq_q [commit_els_p];
  commit_s                  cq_d [commit_els_p];
  logic [cq_ptr_w_lp-1:0]   cq_rptr_q, cq_rptr_d, cq_wptr_q, cq_wptr_d;
  logic [cq_cnt_w_lp-1:0]   cq_cnt_q, cq_cnt_d;

  // Index 0..31 are int registers, 32..63 are fp registers; slot 0 is the buffer head.
  logic [dword_width_p-1:0] wb_data_q [wb_regs_lp][wb_els_p];
  logic [dword_width_p-1:0] wb_data_d [wb_regs_lp][wb_els_p];
  logic [wb_cnt_w_lp-1:0]   wb_cnt_q  [wb_regs_lp];
  logic [wb_cnt_w_lp-1:0]   wb_cnt_d  [wb_regs_lp];

  logic overflow_q, overflow_d;

  commit_s    head;
  logic [4:0] head_rd;
  logic [5:0] head_idx;
  logic       head_uses_wb, head_ready, rec_v, cq_empty, cq_full, deq;
  logic       cq_enq, cq_ovf, wb_ovf;

  // Head resolution on registered state
  always_comb begin
    head         = cq_q[cq_rptr_q];
    head_rd      = head.instr[11:7];
    head_uses_wb = ~head.trap & (head.frd | (head.ird & (head_rd != 5'd0)));
    head_idx     = {head.frd, head_rd};
    cq_empty     = (cq_cnt_q == '0);
    cq_full      = (cq_cnt_q == cq_cnt_w_lp'(commit_els_p));
    head_ready   = ~head_uses_wb | (wb_cnt_q[head_idx] != '0);
    rec_v        = ~cq_empty & head_ready;
    deq          = rec_v & rec_yumi_i;
  end

  // Record fields are forced to zero whenever no record is offered
  always_comb begin
    rec_v_o       = rec_v;
    rec_trap_o    = 1'b0;
    rec_pc_o      = '0;
    rec_instr_o   = '0;
    rec_rd_w_v_o  = 1'b0;
    rec_rd_fp_o   = 1'b0;
    rec_rd_addr_o = '0;
    rec_rd_data_o = '0;
    if (rec_v) begin
      rec_trap_o    = head.trap;
      rec_pc_o      = head.pc;
      rec_instr_o   = head.instr;
      rec_rd_w_v_o  = head_uses_wb;
      rec_rd_fp_o   = head_uses_wb & head.frd;
      rec_rd_addr_o = head_uses_wb ? head_rd : 5'd0;
      if (head.trap)
        rec_rd_data_o = head.cause;
      else if (head_uses_wb)
        rec_rd_data_o = wb_data_q[head_idx][0];
    end
  end

  // Commit queue: circular buffer, no backpressure to the core
  always_comb begin
    cq_d      = cq_q;
    cq_wptr_d = cq_wptr_q;
    cq_rptr_d = cq_rptr_q;
    cq_enq    = commit_v_i & (~cq_full | deq);
    cq_ovf    = commit_v_i & cq_full & ~deq;
    if (cq_enq) begin
      cq_d[cq_wptr_q].trap  = commit_trap_i;
      cq_d[cq_wptr_q].pc    = commit_pc_i;
      cq_d[cq_wptr_q].instr = commit_instr_i;
      cq_d[cq_wptr_q].ird   = commit_ird_w_v_i;
      cq_d[cq_wptr_q].frd   = commit_frd_w_v_i;
      cq_d[cq_wptr_q].cause = commit_cause_i;
      cq_wptr_d             = cq_wptr_q + cq_ptr_w_lp'(1);
    end
    if (deq)
      cq_rptr_d = cq_rptr_q + cq_ptr_w_lp'(1);
    cq_cnt_d = cq_cnt_q + cq_cnt_w_lp'(cq_enq) - cq_cnt_w_lp'(deq);
  end

  // Per-register writeback FIFOs, shift-down on pop so the head is always slot 0
  always_comb begin
    logic                     wb_pop;
    logic                     wb_push;
    logic                     wb_full;
    logic [wb_cnt_w_lp-1:0]   wb_pos;
    logic [dword_width_p-1:0] wb_push_data;
    wb_data_d    = wb_data_q;
    wb_cnt_d     = wb_cnt_q;
    wb_ovf       = 1'b0;
    wb_pop       = 1'b0;
    wb_push      = 1'b0;
    wb_full      = 1'b0;
    wb_pos       = '0;
    wb_push_data = '0;
    for (int unsigned i = 0; i < wb_regs_lp; i++) begin
      wb_pop = deq & head_uses_wb & (head_idx == 6'(i));
      if (i < 32) begin
        wb_push      = iwb_v_i & (iwb_addr_i == 5'(i)) & (iwb_addr_i != 5'd0);
        wb_push_data = iwb_data_i;
      end else begin
        wb_push      = fwb_v_i & (fwb_addr_i == 5'(i - 32));
        wb_push_data = fwb_data_i;
      end
      wb_full = (wb_cnt_q[i] == wb_cnt_w_lp'(wb_els_p));
      wb_pos  = wb_cnt_q[i];
      if (wb_pop) begin
        for (int unsigned k = 0; k + 1 < wb_els_p; k++)
          wb_data_d[i][k] = wb_data_q[i][k+1];
        wb_pos = wb_cnt_q[i] - wb_cnt_w_lp'(1);
      end
      if (wb_push & (~wb_full | wb_pop)) begin
        for (int unsigned k = 0; k < wb_els_p; k++)
          if (wb_pos == wb_cnt_w_lp'(k))
            wb_data_d[i][k] = wb_push_data;
        if (!wb_pop)
          wb_cnt_d[i] = wb_cnt_q[i] + wb_cnt_w_lp'(1);
      end else if (wb_pop) begin
        wb_cnt_d[i] = wb_cnt_q[i] - wb_cnt_w_lp'(1);
      end
      if (wb_push & wb_full & ~wb_pop)
        wb_ovf = 1'b1;
    end
  end

  always_comb begin
    overflow_d = overflow_q | cq_ovf | wb_ovf;
  end

  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cq_rptr_q  <= '0;
      cq_wptr_q  <= '0;
      cq_cnt_q   <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < wb_regs_lp; i++)
        wb_cnt_q[i] <= '0;
    end else begin
      cq_rptr_q  <= cq_rptr_d;
      cq_wptr_q  <= cq_wptr_d;
      cq_cnt_q   <= cq_cnt_d;
      overflow_q <= overflow_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind the counters
  always_ff @(posedge clk_i) begin
    cq_q      <= cq_d;
    wb_data_q <= wb_data_d;
  end

  yumi_requires_valid: assert property (@(posedge clk_i) disable iff (reset_i) rec_yumi_i |-> rec_v);

endmodule

// File: tb/tb_bp_nonsynth_commit_packer.sv
// Bench for the commit packer: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the commit stream and per-register writeback buffers.
module tb_bp_nonsynth_commit_packer;
  localparam int unsigned VA = 39;
  localparam int unsigned DW = 64;
  localparam int unsigned CE = 16;
  localparam int unsigned WE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, commit_v_i, commit_trap_i, commit_ird_w_v_i, commit_frd_w_v_i;
  logic [VA-1:0] commit_pc_i;
  logic [31:0]   commit_instr_i;
  logic [DW-1:0] commit_cause_i, iwb_data_i, fwb_data_i;
  logic          iwb_v_i, fwb_v_i, rec_yumi_i;
  logic [4:0]    iwb_addr_i, fwb_addr_i;
  logic          rec_v_o, rec_trap_o, rec_rd_w_v_o, rec_rd_fp_o, overflow_o;
  logic [VA-1:0] rec_pc_o;
  logic [31:0]   rec_instr_o;
  logic [4:0]    rec_rd_addr_o;
  logic [DW-1:0] rec_rd_data_o;

  bp_nonsynth_commit_packer #(.vaddr_width_p(VA), .dword_width_p(DW),
                              .commit_els_p(CE), .wb_els_p(WE)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .commit_v_i(commit_v_i), .commit_trap_i(commit_trap_i), .commit_pc_i(commit_pc_i),
    .commit_instr_i(commit_instr_i), .commit_ird_w_v_i(commit_ird_w_v_i),
    .commit_frd_w_v_i(commit_frd_w_v_i), .commit_cause_i(commit_cause_i),
    .iwb_v_i(iwb_v_i), .iwb_addr_i(iwb_addr_i), .iwb_data_i(iwb_data_i),
    .fwb_v_i(fwb_v_i), .fwb_addr_i(fwb_addr_i), .fwb_data_i(fwb_data_i),
    .rec_v_o(rec_v_o), .rec_yumi_i(rec_yumi_i), .rec_trap_o(rec_trap_o),
    .rec_pc_o(rec_pc_o), .rec_instr_o(rec_instr_o), .rec_rd_w_v_o(rec_rd_w_v_o),
    .rec_rd_fp_o(rec_rd_fp_o), .rec_rd_addr_o(rec_rd_addr_o),
    .rec_rd_data_o(rec_rd_data_o), .overflow_o(overflow_o));

  typedef struct {
    bit trap; logic [VA-1:0] pc; logic [31:0] instr; bit ird; bit frd; logic [DW-1:0] cause;
  } cm_t;

  typedef struct {
    bit cv; bit ctrap; bit ird; bit frd; logic [VA-1:0] pc; logic [31:0] instr;
    logic [DW-1:0] cause; bit iv; logic [4:0] ia; logic [DW-1:0] id;
    bit fv; logic [4:0] fa; logic [DW-1:0] fd; bit yumi; bit rst;
  } stim_t;

  cm_t           mq[$];
  logic [DW-1:0] mwb[64][$];
  bit            movf;
  int            checks = 0;
  int            passes = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [31:0] mk(logic [4:0] rd, logic [6:0] opc);
    return {20'h0, rd, opc};
  endfunction

  function automatic stim_t nop(bit y);
    stim_t s;
    s.cv = 0; s.ctrap = 0; s.ird = 0; s.frd = 0; s.pc = '0; s.instr = '0; s.cause = '0;
    s.iv = 0; s.ia = '0; s.id = '0; s.fv = 0; s.fa = '0; s.fd = '0; s.yumi = y; s.rst = 0;
    return s;
  endfunction

  // Which writeback buffer (if any) the oldest commit needs
  function automatic void head_need(output bit uses, output int idx);
    logic [4:0] rd;
    uses = 0; idx = 0;
    if (mq.size() == 0) return;
    rd = mq[0].instr[11:7];
    if (mq[0].trap) uses = 0;
    else if (mq[0].frd) begin uses = 1; idx = 32 + int'(rd); end
    else if (mq[0].ird && rd != 5'd0) begin uses = 1; idx = int'(rd); end
  endfunction

  function automatic void model_out(output bit v, output bit t, output logic [VA-1:0] pc,
                                    output logic [31:0] ins, output bit w, output bit fp,
                                    output logic [4:0] a, output logic [DW-1:0] d);
    bit uses; int idx;
    v = 0; t = 0; pc = '0; ins = '0; w = 0; fp = 0; a = '0; d = '0;
    if (mq.size() == 0) return;
    head_need(uses, idx);
    if (uses && mwb[idx].size() == 0) return;
    v = 1; t = mq[0].trap; pc = mq[0].pc; ins = mq[0].instr;
    if (mq[0].trap) d = mq[0].cause;
    else if (uses) begin
      w = 1; fp = mq[0].frd; a = mq[0].instr[11:7]; d = mwb[idx][0];
    end
  endfunction

  function automatic void model_update(stim_t s, bit y);
    bit uses; int idx;
    cm_t c;
    if (s.rst) begin
      mq.delete();
      for (int i = 0; i < 64; i++) mwb[i].delete();
      movf = 0;
      return;
    end
    if (y) begin
      head_need(uses, idx);
      void'(mq.pop_front());
      if (uses) void'(mwb[idx].pop_front());
    end
    if (s.iv && s.ia != 5'd0) begin
      if (mwb[int'(s.ia)].size() < WE) mwb[int'(s.ia)].push_back(s.id); else movf = 1;
    end
    if (s.fv) begin
      if (mwb[32 + int'(s.fa)].size() < WE) mwb[32 + int'(s.fa)].push_back(s.fd); else movf = 1;
    end
    if (s.cv) begin
      c.trap = s.ctrap; c.pc = s.pc; c.instr = s.instr; c.ird = s.ird; c.frd = s.frd;
      c.cause = s.cause;
      if (mq.size() < CE) mq.push_back(c); else movf = 1;
    end
  endfunction

  // One cycle: compare outputs against the model, drive inputs, advance past the edge
  task automatic step(input stim_t s);
    bit ev, et, ew, ef, y;
    logic [VA-1:0] ep; logic [31:0] ei; logic [4:0] ea; logic [DW-1:0] ed;
    model_out(ev, et, ep, ei, ew, ef, ea, ed);
    chk("rec_v", rec_v_o, ev);
    chk("rec_trap", rec_trap_o, et);
    chk("rec_pc", rec_pc_o, ep);
    chk("rec_instr", rec_instr_o, ei);
    chk("rec_rd_w_v", rec_rd_w_v_o, ew);
    chk("rec_rd_fp", rec_rd_fp_o, ef);
    chk("rec_rd_addr", rec_rd_addr_o, ea);
    chk("rec_rd_data", rec_rd_data_o, ed);
    chk("overflow", overflow_o, movf);
    y = s.yumi & ev & ~s.rst;
    reset_i = s.rst; rec_yumi_i = y;
    commit_v_i = s.cv; commit_trap_i = s.ctrap; commit_pc_i = s.pc; commit_instr_i = s.instr;
    commit_ird_w_v_i = s.ird; commit_frd_w_v_i = s.frd; commit_cause_i = s.cause;
    iwb_v_i = s.iv; iwb_addr_i = s.ia; iwb_data_i = s.id;
    fwb_v_i = s.fv; fwb_addr_i = s.fa; fwb_data_i = s.fd;
    model_update(s, y);
    @(posedge clk); #1;
  endtask

  initial begin
    stim_t s;
    int n, r;
    reset_i = 1; rec_yumi_i = 0; commit_v_i = 0; commit_trap_i = 0; commit_pc_i = '0;
    commit_instr_i = '0; commit_ird_w_v_i = 0; commit_frd_w_v_i = 0; commit_cause_i = '0;
    iwb_v_i = 0; iwb_addr_i = '0; iwb_data_i = '0; fwb_v_i = 0; fwb_addr_i = '0; fwb_data_i = '0;
    movf = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 0;
    chk("reset_v", rec_v_o, 0);
    chk("reset_ovf", overflow_o, 0);
    chk("reset_data", rec_rd_data_o, 0);

    // ALU stream with same-cycle writebacks
    for (int i = 1; i <= 3; i++) begin
      s = nop(1); s.cv = 1; s.ird = 1; s.instr = mk(5'(i), 7'h33); s.pc = VA'(32'h1000 + 4*i);
      s.iv = 1; s.ia = 5'(i); s.id = DW'(8'h11 * i);
      step(s);
      chk("alu_v", rec_v_o, 1);
      chk("alu_data", rec_rd_data_o, DW'(8'h11 * i));
    end
    step(nop(1));
    chk("alu_drained", rec_v_o, 0);

    // Late fp writeback blocks a younger ready int record
    s = nop(1); s.cv = 1; s.frd = 1; s.instr = mk(5'd4, 7'h53); s.pc = VA'(32'h2000);
    step(s);
    chk("late_wait0", rec_v_o, 0);
    s = nop(1); s.cv = 1; s.ird = 1; s.instr = mk(5'd5, 7'h33); s.pc = VA'(32'h2004);
    s.iv = 1; s.ia = 5'd5; s.id = 64'h55;
    step(s);
    for (int i = 0; i < 12; i++) begin
      chk("late_blocked", rec_v_o, 0);
      step(nop(1));
    end
    s = nop(1); s.fv = 1; s.fa = 5'd4; s.fd = 64'h4010_0000_0000_0000;
    step(s);
    chk("late_f4_v", rec_v_o, 1);
    chk("late_f4_fp", rec_rd_fp_o, 1);
    chk("late_f4_data", rec_rd_data_o, 64'h4010_0000_0000_0000);
    step(nop(1));
    chk("late_x5_addr", rec_rd_addr_o, 5);
    chk("late_x5_data", rec_rd_data_o, 64'h55);
    step(nop(1));

    // Trap record carries the cause
    s = nop(1); s.cv = 1; s.ctrap = 1; s.pc = VA'(32'h8000_0100); s.instr = 32'h0000_0073;
    s.cause = 64'hd; s.ird = 1;
    step(s);
    chk("trap_flag", rec_trap_o, 1);
    chk("trap_rdw", rec_rd_w_v_o, 0);
    chk("trap_data", rec_rd_data_o, 64'hd);
    chk("trap_pc", rec_pc_o, 64'h8000_0100);
    step(nop(1));

    // x0 destination and store resolve immediately
    s = nop(1); s.cv = 1; s.ird = 1; s.instr = mk(5'd0, 7'h13);
    step(s);
    chk("x0_v", rec_v_o, 1);
    chk("x0_rdw", rec_rd_w_v_o, 0);
    s = nop(1); s.cv = 1; s.instr = 32'h0011_2423;
    step(s);
    chk("sw_v", rec_v_o, 1);
    chk("sw_data", rec_rd_data_o, 0);
    step(nop(1));

    // Commit queue overrun
    for (int i = 0; i < 17; i++) begin
      s = nop(0); s.cv = 1; s.instr = 32'h0000_0023; s.pc = VA'(i * 4);
      step(s);
      if (i == 15) chk("cq_not_yet_ovf", overflow_o, 0);
    end
    chk("cq_ovf", overflow_o, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (rec_v_o === 1'b1) n++;
      step(nop(1));
    end
    chk("cq_kept", DW'(n), 16);

    // Writeback buffer overrun
    s = nop(0); s.rst = 1; step(s);
    for (int i = 0; i < 3; i++) begin
      s = nop(0); s.iv = 1; s.ia = 5'd7; s.id = DW'(i);
      step(s);
      if (i == 1) chk("wb_not_yet_ovf", overflow_o, 0);
    end
    chk("wb_ovf", overflow_o, 1);

    // Reset with records pending
    for (int i = 0; i < 5; i++) begin
      s = nop(0); s.cv = 1; s.instr = 32'h0000_0023; step(s);
    end
    chk("pending_v", rec_v_o, 1);
    s = nop(0); s.rst = 1; step(s);
    chk("mid_rst_v", rec_v_o, 0);
    chk("mid_rst_ovf", overflow_o, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      s = nop($urandom_range(99) < 70);
      if ($urandom_range(99) < 40) begin
        r = $urandom_range(99);
        s.cv = 1; s.ctrap = (r < 10); s.ird = (r >= 10 && r < 50); s.frd = (r >= 50 && r < 75);
        s.instr = $urandom; s.instr[11:7] = 5'($urandom_range(3));
        s.pc = VA'({$urandom, $urandom}); s.cause = {$urandom, $urandom};
      end
      if ($urandom_range(99) < 35) begin
        s.iv = 1; s.ia = 5'($urandom_range(3)); s.id = {$urandom, $urandom};
      end
      if ($urandom_range(99) < 25) begin
        s.fv = 1; s.fa = 5'($urandom_range(3)); s.fd = {$urandom, $urandom};
      end
      s.rst = ($urandom_range(999) < 3);
      step(s);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
